int_ctrl: RTL and testbench

Machine-mode trap sequencer that drives the interrupt-side CSR port of `csr_reg`. It detects `ecall`, `ebreak`, `mret` and external/timer interrupt requests, then holds the pipeline. It performs the mepc/mstatus/mcause CSR writes one per cycle and issues a one-cycle redirect to `mtvec` or `mepc`. It sits beside `ex` and `ctrl`: its hold output feeds `ctrl`, and its redirect feeds the PC/flush logic.

---
 rtl/int_ctrl_pkg.sv | 48 ++++
 rtl/int_ctrl.sv | 142 ++++++++++++++
 tb/tb_int_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants for the machine-mode trap sequencer: opcodes, trap causes,
// CSR addresses, FSM state encoding and the mstatus rewrite helpers.
package int_ctrl_pkg;

   localparam int REG_BUS       = 32;
   localparam int DATA_ADDR_BUS = 32;

   localparam logic [REG_BUS-1:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [REG_BUS-1:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [REG_BUS-1:0] INST_MRET   = 32'h3020_0073;

   localparam logic [REG_BUS-1:0] CAUSE_ECALL     = 32'h0000_000B;
   localparam logic [REG_BUS-1:0] CAUSE_EBREAK    = 32'h0000_0003;
   localparam logic [REG_BUS-1:0] CAUSE_IRQ_EXT   = 32'h8000_000B;
   localparam logic [REG_BUS-1:0] CAUSE_IRQ_TIMER = 32'h8000_0007;

   localparam logic [DATA_ADDR_BUS-1:0] CSR_MSTATUS = 32'h0000_0300;
   localparam logic [DATA_ADDR_BUS-1:0] CSR_MEPC    = 32'h0000_0341;
   localparam logic [DATA_ADDR_BUS-1:0] CSR_MCAUSE  = 32'h0000_0342;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      W_MEPC    = 3'd1,
      W_MSTATUS = 3'd2,
      W_MCAUSE  = 3'd3,
      MRET_ST   = 3'd4,
      ASSERT    = 3'd5
   } state_e;

   // Trap entry: MPIE <= MIE, MIE <= 0.
   function automatic logic [REG_BUS-1:0] trap_mstatus(input logic [REG_BUS-1:0] m);
      logic [REG_BUS-1:0] r;
      r    = m;
      r[7] = m[3];
      r[3] = 1'b0;
      return r;
   endfunction

   // Trap return: MIE <= MPIE, MPIE <= 1.
   function automatic logic [REG_BUS-1:0] mret_mstatus(input logic [REG_BUS-1:0] m);
      logic [REG_BUS-1:0] r;
      r    = m;
      r[3] = m[7];
      r[7] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/int_ctrl.sv
// Machine-mode trap sequencer: detects ecall/ebreak/mret/irqs, stalls the pipe,
// writes mepc/mstatus/mcause one per cycle and emits a one-cycle redirect.
module int_ctrl
   import int_ctrl_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [REG_BUS-1:0]       inst_i,
   input  logic [DATA_ADDR_BUS-1:0] inst_addr_i,
   input  logic                     jump_flag_i,
   input  logic [DATA_ADDR_BUS-1:0] jump_addr_i,
   input  logic                     irq_ext_i,
   input  logic                     irq_timer_i,
   input  logic                     global_int_en_i,
   input  logic [REG_BUS-1:0]       csr_mtvec_i,
   input  logic [REG_BUS-1:0]       csr_mepc_i,
   input  logic [REG_BUS-1:0]       csr_mstatus_i,
   output logic                     csr_we_o,
   output logic [DATA_ADDR_BUS-1:0] csr_waddr_o,
   output logic [DATA_ADDR_BUS-1:0] csr_raddr_o,
   output logic [REG_BUS-1:0]       csr_wdata_o,
   output logic                     hold_flag_o,
   output logic                     int_assert_o,
   output logic [DATA_ADDR_BUS-1:0] int_addr_o
);

   state_e                   state_q;
   logic [REG_BUS-1:0]       cause_q;
   logic [DATA_ADDR_BUS-1:0] epc_q;
   logic [REG_BUS-1:0]       mstatus_q;
   logic                     mret_q;
   logic                     csr_we_q;
   logic [DATA_ADDR_BUS-1:0] csr_waddr_q;
   logic [REG_BUS-1:0]       csr_wdata_q;
   logic                     assert_q;

   logic                     trap_det;
   logic                     mret_det;
   logic [REG_BUS-1:0]       cause_d;
   logic [DATA_ADDR_BUS-1:0] epc_d;
   logic                     detect;

   always_comb begin
      trap_det = 1'b0;
      mret_det = 1'b0;
      cause_d  = '0;
      epc_d    = '0;
      if (inst_i == INST_ECALL) begin
         trap_det = 1'b1;
         cause_d  = CAUSE_ECALL;
         epc_d    = inst_addr_i;
      end else if (inst_i == INST_EBREAK) begin
         trap_det = 1'b1;
         cause_d  = CAUSE_EBREAK;
         epc_d    = inst_addr_i;
      end else if (inst_i == INST_MRET) begin
         mret_det = 1'b1;
      end else if (global_int_en_i && (irq_ext_i || irq_timer_i)) begin
         // An interrupt must resume at the branch target if ex is redirecting.
         trap_det = 1'b1;
         cause_d  = irq_ext_i ? CAUSE_IRQ_EXT : CAUSE_IRQ_TIMER;
         epc_d    = jump_flag_i ? jump_addr_i : inst_addr_i;
      end
   end

   assign detect = (state_q == IDLE) && (trap_det || mret_det);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cause_q     <= '0;
         epc_q       <= '0;
         mstatus_q   <= '0;
         mret_q      <= 1'b0;
         csr_we_q    <= 1'b0;
         csr_waddr_q <= '0;
         csr_wdata_q <= '0;
         assert_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (trap_det) begin
                  state_q     <= W_MEPC;
                  cause_q     <= cause_d;
                  epc_q       <= epc_d;
                  mstatus_q   <= csr_mstatus_i;
                  mret_q      <= 1'b0;
                  csr_we_q    <= 1'b1;
                  csr_waddr_q <= CSR_MEPC;
                  csr_wdata_q <= epc_d;
               end else if (mret_det) begin
                  state_q     <= MRET_ST;
                  mstatus_q   <= csr_mstatus_i;
                  mret_q      <= 1'b1;
                  csr_we_q    <= 1'b1;
                  csr_waddr_q <= CSR_MSTATUS;
                  csr_wdata_q <= mret_mstatus(csr_mstatus_i);
               end
            end
            W_MEPC: begin
               state_q     <= W_MSTATUS;
               csr_waddr_q <= CSR_MSTATUS;
               csr_wdata_q <= trap_mstatus(mstatus_q);
            end
            W_MSTATUS: begin
               state_q     <= W_MCAUSE;
               csr_waddr_q <= CSR_MCAUSE;
               csr_wdata_q <= cause_q;
            end
            W_MCAUSE, MRET_ST: begin
               state_q     <= ASSERT;
               csr_we_q    <= 1'b0;
               csr_waddr_q <= '0;
               csr_wdata_q <= '0;
               assert_q    <= 1'b1;
            end
            ASSERT: begin
               state_q  <= IDLE;
               assert_q <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               csr_we_q    <= 1'b0;
               csr_waddr_q <= '0;
               csr_wdata_q <= '0;
               assert_q    <= 1'b0;
            end
         endcase
      end
   end

   assign csr_we_o     = csr_we_q;
   assign csr_waddr_o  = csr_waddr_q;
   assign csr_wdata_o  = csr_wdata_q;
   assign csr_raddr_o  = CSR_MSTATUS;
   // The detect term is gated by rst so hold drops the instant reset asserts.
   assign hold_flag_o  = rst && ((state_q != IDLE) || detect);
   assign int_assert_o = assert_q;
   // Redirect target is read live so a write earlier in the sequence is seen.
   assign int_addr_o   = assert_q ? (mret_q ? csr_mepc_i : csr_mtvec_i) : '0;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: table of trap/mret/irq scenarios expanded into per-cycle
// expected records on a scoreboard queue, plus a mid-sequence reset scenario.
module tb_int_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] inst_i, inst_addr_i, jump_addr_i;
   logic        jump_flag_i, irq_ext_i, irq_timer_i;
   logic        csr_we_o, hold_flag_o, int_assert_o;
   logic [31:0] csr_waddr_o, csr_raddr_o, csr_wdata_o, int_addr_o;

   // Minimal csr_reg stand-in: takes the sequencer's writes, feeds mstatus/mepc/mtvec back.
   logic [31:0] m_mstatus, m_mepc, m_mtvec, m_mcause;
   logic        load_en;
   logic [31:0] ld_mstatus, ld_mepc, ld_mtvec;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (load_en) begin
         m_mstatus <= ld_mstatus;
         m_mepc    <= ld_mepc;
         m_mtvec   <= ld_mtvec;
         m_mcause  <= 32'h0;
      end else if (csr_we_o) begin
         case (csr_waddr_o[11:0])
            12'h300: m_mstatus <= csr_wdata_o;
            12'h341: m_mepc    <= csr_wdata_o;
            12'h342: m_mcause  <= csr_wdata_o;
            default: ;
         endcase
      end
   end

   int_ctrl dut (
      .clk(clk), .rst(rst),
      .inst_i(inst_i), .inst_addr_i(inst_addr_i),
      .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
      .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
      .global_int_en_i(m_mstatus[3]),
      .csr_mtvec_i(m_mtvec), .csr_mepc_i(m_mepc), .csr_mstatus_i(m_mstatus),
      .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_raddr_o(csr_raddr_o),
      .csr_wdata_o(csr_wdata_o), .hold_flag_o(hold_flag_o),
      .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
   );

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;

   typedef struct {
      string       name;
      logic [31:0] inst, pc;
      logic        jf;
      logic [31:0] jaddr;
      logic        ext, tim;
      logic [31:0] mstatus, mepc, mtvec;
      int          kind;      // 0 nothing taken, 1 trap, 2 mret
      logic [31:0] exp_epc, exp_mst, exp_cause, exp_target;
   } vec_t;

   typedef struct {
      logic        we;
      logic [31:0] waddr, wdata;
      logic        hold, ast;
      logic [31:0] addr;
   } rec_t;

   rec_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic rec_t mk(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                               input logic hold, input logic ast, input logic [31:0] addr);
      rec_t r;
      r.we = we; r.waddr = wa; r.wdata = wd; r.hold = hold; r.ast = ast; r.addr = addr;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pop_check(input string name, input int cyc);
      rec_t e;
      total++;
      if (sb_q.size() == 0) begin
         bad++;
         $display("FAIL %s cyc%0d: scoreboard empty", name, cyc);
      end else begin
         e = sb_q.pop_front();
         if (csr_we_o !== e.we || csr_waddr_o !== e.waddr || csr_wdata_o !== e.wdata ||
             hold_flag_o !== e.hold || int_assert_o !== e.ast || int_addr_o !== e.addr ||
             csr_raddr_o !== 32'h300) begin
            bad++;
            $display("FAIL %s cyc%0d: got we=%b wa=%h wd=%h hold=%b ast=%b addr=%h ra=%h expected we=%b wa=%h wd=%h hold=%b ast=%b addr=%h ra=00000300",
                     name, cyc, csr_we_o, csr_waddr_o, csr_wdata_o, hold_flag_o, int_assert_o,
                     int_addr_o, csr_raddr_o, e.we, e.waddr, e.wdata, e.hold, e.ast, e.addr);
         end else begin
            $display("ok   %s cyc%0d: we=%b wa=%h wd=%h hold=%b ast=%b addr=%h",
                     name, cyc, csr_we_o, csr_waddr_o, csr_wdata_o, hold_flag_o,
                     int_assert_o, int_addr_o);
         end
      end
   endtask

   task automatic idle_inputs();
      inst_i = NOP; inst_addr_i = 32'h0; jump_flag_i = 1'b0; jump_addr_i = 32'h0;
      irq_ext_i = 1'b0; irq_timer_i = 1'b0;
   endtask

   task automatic load_csrs(input logic [31:0] ms, input logic [31:0] ep, input logic [31:0] tv);
      @(posedge clk); #1;
      ld_mstatus = ms; ld_mepc = ep; ld_mtvec = tv; load_en = 1'b1;
      @(posedge clk); #1;
      load_en = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      load_csrs(v.mstatus, v.mepc, v.mtvec);
      inst_i = v.inst; inst_addr_i = v.pc; jump_flag_i = v.jf; jump_addr_i = v.jaddr;
      irq_ext_i = v.ext; irq_timer_i = v.tim;
      case (v.kind)
         1: begin
            sb_q.push_back(mk(1'b0, 32'h0,   32'h0,       1'b1, 1'b0, 32'h0));
            sb_q.push_back(mk(1'b1, 32'h341, v.exp_epc,   1'b1, 1'b0, 32'h0));
            sb_q.push_back(mk(1'b1, 32'h300, v.exp_mst,   1'b1, 1'b0, 32'h0));
            sb_q.push_back(mk(1'b1, 32'h342, v.exp_cause, 1'b1, 1'b0, 32'h0));
            sb_q.push_back(mk(1'b0, 32'h0,   32'h0,       1'b1, 1'b1, v.exp_target));
         end
         2: begin
            sb_q.push_back(mk(1'b0, 32'h0,   32'h0,     1'b1, 1'b0, 32'h0));
            sb_q.push_back(mk(1'b1, 32'h300, v.exp_mst, 1'b1, 1'b0, 32'h0));
            sb_q.push_back(mk(1'b0, 32'h0,   32'h0,     1'b1, 1'b1, v.exp_target));
         end
         default: ;
      endcase
      // Quiet tail: proves one-cycle assert and no re-entry while irq lines stay high.
      for (int k = 0; k < 3; k++) sb_q.push_back(mk(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0));
      n = sb_q.size();
      for (int c = 0; c < n; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            inst_i = NOP; jump_flag_i = 1'b0;
         end
         @(negedge clk);
         pop_check(v.name, c);
      end
      if (v.kind == 1) chk({v.name, " mcause stored"}, m_mcause, v.exp_cause);
      idle_inputs();
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{"ecall",       ECALL,  32'h100, 1'b0, 32'h0,   1'b0, 1'b0, 32'h8,    32'h0,   32'h200,
                  1, 32'h100, 32'h80,   32'hB,         32'h200};
      vecs[1] = '{"mret",        MRET,   32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h80,   32'h104, 32'h200,
                  2, 32'h0,   32'h88,   32'h0,         32'h104};
      vecs[2] = '{"irq_ext_jmp", NOP,    32'h50,  1'b1, 32'h300, 1'b1, 1'b0, 32'h8,    32'h0,   32'h400,
                  1, 32'h300, 32'h80,   32'h8000000B,  32'h400};
      vecs[3] = '{"timer_mie0",  NOP,    32'h60,  1'b0, 32'h0,   1'b0, 1'b1, 32'h0,    32'h0,   32'h400,
                  0, 32'h0,   32'h0,    32'h0,         32'h0};
      vecs[4] = '{"timer_mie1",  NOP,    32'h60,  1'b0, 32'h0,   1'b0, 1'b1, 32'h8,    32'h0,   32'h480,
                  1, 32'h60,  32'h80,   32'h80000007,  32'h480};
      vecs[5] = '{"ebreak_ext",  EBREAK, 32'h70,  1'b0, 32'h0,   1'b1, 1'b0, 32'h1808, 32'h0,   32'h200,
                  1, 32'h70,  32'h1880, 32'h3,         32'h200};
      vecs[6] = '{"ecall_tim_jf", ECALL, 32'h104, 1'b1, 32'h999, 1'b0, 1'b1, 32'h80,   32'h0,   32'h240,
                  1, 32'h104, 32'h0,    32'hB,         32'h240};
      vecs[7] = '{"mret_mpie0",  MRET,   32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h8,    32'h220, 32'h200,
                  2, 32'h0,   32'h80,   32'h0,         32'h220};
      vecs[8] = '{"mret_vs_tim", MRET,   32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h8,    32'h2A0, 32'h200,
                  2, 32'h0,   32'h80,   32'h0,         32'h2A0};

      rst = 1'b0;
      idle_inputs();
      ld_mstatus = 32'h0; ld_mepc = 32'h0; ld_mtvec = 32'h0; load_en = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      inst_i = ECALL;   // detect condition present but reset must still hold everything low
      chk("reset we",     {31'h0, csr_we_o},     32'h0);
      chk("reset waddr",  csr_waddr_o,           32'h0);
      chk("reset wdata",  csr_wdata_o,           32'h0);
      chk("reset hold",   {31'h0, hold_flag_o},  32'h0);
      chk("reset assert", {31'h0, int_assert_o}, 32'h0);
      chk("reset addr",   int_addr_o,            32'h0);
      chk("reset raddr",  csr_raddr_o,           32'h300);
      inst_i = NOP;
      load_en = 1'b0;
      @(negedge clk); rst = 1'b1;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset pulled mid-sequence during W_MSTATUS: everything drops at once, nothing resumes.
      load_csrs(32'h8, 32'h0, 32'h200);
      inst_i = ECALL; inst_addr_i = 32'h500;
      @(posedge clk); #1;
      @(posedge clk); #2;
      chk("midrst in W_MSTATUS we", {31'h0, csr_we_o}, 32'h1);
      chk("midrst in W_MSTATUS wa", csr_waddr_o, 32'h300);
      rst = 1'b0;
      #1;
      chk("midrst we",     {31'h0, csr_we_o},     32'h0);
      chk("midrst waddr",  csr_waddr_o,           32'h0);
      chk("midrst wdata",  csr_wdata_o,           32'h0);
      chk("midrst hold",   {31'h0, hold_flag_o},  32'h0);
      chk("midrst assert", {31'h0, int_assert_o}, 32'h0);
      chk("midrst raddr",  csr_raddr_o,           32'h300);
      @(posedge clk); @(posedge clk); #1;
      inst_i = NOP;
      @(negedge clk); rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("post-rst cyc%0d we", c),     {31'h0, csr_we_o},     32'h0);
         chk($sformatf("post-rst cyc%0d hold", c),   {31'h0, hold_flag_o},  32'h0);
         chk($sformatf("post-rst cyc%0d assert", c), {31'h0, int_assert_o}, 32'h0);
      end
      chk("post-rst mstatus untouched", m_mstatus, 32'h8);
      chk("post-rst mepc written before reset", m_mepc, 32'h500);
      chk("scoreboard drained", sb_q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
